// File: rtl/if_ctrl_if.sv
// Fetch-unit bus bundle: instruction-memory port, redirect input and decode handshake.
interface if_ctrl_if #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned INST_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_gnt;
  logic              imem_rvalid;
  logic [INST_W-1:0] imem_rdata;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              inst_valid;
  logic              inst_ready;
  logic [INST_W-1:0] inst;
  logic [ADDR_W-1:0] inst_pc;
  logic [63:0]       fetch_cnt;

  modport master (
    output imem_req, imem_addr, inst_valid, inst, inst_pc, fetch_cnt,
    input  imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, inst_ready
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, inst_pc, fetch_cnt,
    output imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, inst_ready
  );
endinterface

// File: rtl/if_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues one outstanding imem fetch at a time,
// hands instructions to decode and applies execute redirects, discarding stale responses.
module if_ctrl #(
  parameter logic [63:0] PC_RESET = 64'h8000_0000,
  parameter int unsigned ADDR_W   = 64,
  parameter int unsigned INST_W   = 32
) (
  input logic      clk,
  input logic      rst_n,
  if_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    DROP = 3'd3,
    HOLD = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
  logic [63:0]       cnt_q, cnt_d;
  logic              req_q, valid_q;
  logic [ADDR_W-1:0] redir_pc;

  // Redirect targets are forced word-aligned.
  assign redir_pc = bus.redirect_pc & ~ADDR_W'(3);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (bus.redirect_valid) pc_d = redir_pc;
        if (bus.imem_gnt) state_d = bus.redirect_valid ? DROP : WAIT;
      end
      WAIT: begin
        if (bus.imem_rvalid) begin
          if (bus.redirect_valid) begin
            state_d = REQ;
            pc_d    = redir_pc;
          end else begin
            state_d   = HOLD;
            inst_d    = bus.imem_rdata;
            inst_pc_d = pc_q;
            pc_d      = pc_q + ADDR_W'(4);
          end
        end else if (bus.redirect_valid) begin
          state_d = DROP;
          pc_d    = redir_pc;
        end
      end
      DROP: begin
        // The in-flight response belongs to the old PC; swallow it before refetching.
        if (bus.redirect_valid) pc_d = redir_pc;
        if (bus.imem_rvalid) state_d = REQ;
      end
      HOLD: begin
        if (bus.redirect_valid) begin
          state_d = REQ;
          pc_d    = redir_pc;
        end else if (bus.inst_ready) begin
          state_d = REQ;
          cnt_d   = cnt_q + 64'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pc_q      <= ADDR_W'(PC_RESET);
      inst_q    <= '0;
      inst_pc_q <= '0;
      cnt_q     <= '0;
      req_q     <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      cnt_q     <= cnt_d;
      req_q     <= (state_d == REQ);
      valid_q   <= (state_d == HOLD);
    end
  end

  assign bus.imem_req   = req_q;
  assign bus.imem_addr  = pc_q;
  assign bus.inst_valid = valid_q;
  assign bus.inst       = inst_q;
  assign bus.inst_pc    = inst_pc_q;
  assign bus.fetch_cnt  = cnt_q;

endmodule
